kstep_step_decoder: RTL and testbench
=====================================

# kstep_step_decoder

Step/dir input decoder for the kstep design: the receiving end of the step/dir interface that the kstep step generator drives. It synchronizes and glitch-filters external `step`/`dir` lines, keeps a signed position count, and measures the clock-cycle interval between accepted steps. It is used for loopback self-test of the step generator on silicon and as a position tracker for an external step source.

## Interface
Parameters:
- `POS_WIDTH`, 32: position counter width; two's complement, wraps.
- `INT_WIDTH`, 24: interval measurement width; saturating.
- `SYNC_STAGES`, 2: input synchronizer depth; minimum 2.
- `FILT_CYCLES`, 2: consecutive stable cycles required before a filtered level changes; minimum 1.
- `DIR_SETUP`, 4: minimum cycles the filtered `dir` must be stable before an accepted step edge.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `step_in`  in  1  raw asynchronous step line; the rising edge is the step.
- `dir_in`  in  1  raw asynchronous direction line.
- `dir_invert`  in  1  quasi-static; when 1, the direction sense is inverted.
- `clear`  in  1  synchronous clear of position, timer, and flags.
- `position`  out  POS_WIDTH  current position count.
- `interval`  out  INT_WIDTH  cycles between the last two accepted steps.
- `interval_valid`  out  1  one-cycle pulse when `interval` updates.
- `step_evt`  out  1  one-cycle pulse when `position` updates.
- `dir_err`  out  1  sticky flag for a direction setup violation.
- `stall`  out  1  high while the interval timer is saturated.

## Operation
- **Synchronizer:** `step_in` and `dir_in` each pass through `SYNC_STAGES` flops. All flops reset to 0.
- **Filter:** Each synchronized line has a filtered level and a run counter.
  - The run counter increments while the synchronized value differs from the filtered level. It resets to 0 when they match.
  - When the counter reaches `FILT_CYCLES`, the filtered level takes the synchronized value and the counter returns to 0.
  - Pulses shorter than `FILT_CYCLES` cycles are ignored.
  - Filtered levels reset to 0.
- **Accepted step:** A filtered `step` transition from 0 to 1. Falling edges have no effect.
- **Direction:**
  - Effective direction = filtered `dir` XOR `dir_invert`.
  - 1 → `position` + 1; 0 → `position` − 1.
  - Arithmetic is modulo 2^POS_WIDTH: all-ones + 1 = 0, and 0 − 1 = all-ones.
  - The direction used is the filtered `dir` in the cycle of the accepted edge.
- **Direction setup check:**
  - A counter tracks cycles since the last filtered `dir` change, saturating at `DIR_SETUP`.
  - If an accepted step occurs while this counter is below `DIR_SETUP`, `dir_err` is set. The step is still counted.
  - `dir_err` stays set until `clear` or `rst`.
  - Exception: no error is flagged before the first `dir` change after reset, because the counter resets to saturated.
- **Interval timer:**
  - The timer increments every cycle and saturates at 2^INT_WIDTH − 1. `stall` = (timer is saturated).
  - On an accepted step: if a previous step has been seen since reset/`clear`, `interval` takes the timer value and `interval_valid` pulses. The saturated value is reported as-is.
  - Also on an accepted step, the timer is set to 1 and the "seen" flag is set.
  - The first step after reset/`clear` updates no interval.
- **`clear`:**
  - Zeroes `position` and the timer, clears the "seen" flag and `dir_err`.
  - Leaves `interval`, the synchronizers, and the filters untouched.
  - If `clear` coincides with an accepted step, `clear` wins: the step is discarded and `step_evt` and `interval_valid` stay 0.
- **`rst`:** Every register and output goes to 0, except the setup counter, which goes to saturated. `rst` mid-pulse discards any partial filter progress.

## Timing
- Reset values: `position`=0, `interval`=0, `interval_valid`=0, `step_evt`=0, `dir_err`=0, `stall`=0.
- Latency: raw `step_in` high, first sampled at clock edge k → `position` and `step_evt` update at edge k + SYNC_STAGES + FILT_CYCLES. This is 4 cycles at defaults.
- `interval_valid` and `step_evt` are asserted in the same cycle, and each is exactly one cycle wide.
- Maximum accepted step rate: one step per 2×FILT_CYCLES cycles. Faster toggling is filtered out, not miscounted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset/idle:** hold `rst` for 3 cycles, then idle for 20 cycles → all outputs 0 and no pulses.
- **Forward count:** `dir_in`=1 steady, then 5 clean step pulses (4 high / 4 low) at a 100-cycle period → `position`=5. Exactly 5 `step_evt` pulses and 4 `interval_valid` pulses, each with `interval`=100.
- **Reverse and wrap:** from 0, `dir_in`=0, one step → `position`=all-ones. Then `dir_invert`=1, two steps → `position`=1.
- **Glitch rejection:** `step_in` high for 1 cycle, repeated 10 times (FILT_CYCLES=2) → `position` unchanged and no `step_evt`.
- **Direction setup violation:** toggle `dir_in` 2 cycles before `step_in` rises → step counted in the new direction and `dir_err`=1 until `clear`. With `dir_in` toggled 10 cycles before `step_in`, `dir_err` stays 0.
- **Clear collision and stall:** assert `clear` in the cycle a step would be accepted → `position`=0 and no pulse. With INT_WIDTH=8, wait 300 cycles between steps → `stall`=1 and `interval`=255.

Source files
------------

// File: rtl/kstep_step_decoder.sv
// rtl/kstep_step_decoder.sv - step/dir receiver: synchronize, glitch-filter, count position, time step intervals
module kstep_step_decoder #(
    parameter int POS_WIDTH   = 32,
    parameter int INT_WIDTH   = 24,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 2,
    parameter int DIR_SETUP   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_in,
    input  logic                 dir_in,
    input  logic                 dir_invert,
    input  logic                 clear,
    output logic [POS_WIDTH-1:0] position,
    output logic [INT_WIDTH-1:0] interval,
    output logic                 interval_valid,
    output logic                 step_evt,
    output logic                 dir_err,
    output logic                 stall
);
    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam int SW = $clog2(DIR_SETUP + 1);
    localparam logic [INT_WIDTH-1:0] INT_MAX = '1;

    logic [SYNC_STAGES-1:0] step_sync, dir_sync;
    logic                   step_filt, dir_filt, step_filt_d;
    logic [FW-1:0]          step_run, dir_run;
    logic [SW-1:0]          setup_cnt;
    logic [INT_WIDTH-1:0]   timer, timer_inc;
    logic                   seen;
    logic                   step_s, dir_s, step_flip, dir_flip, accept, eff_dir;

    always_comb begin
        step_s    = step_sync[SYNC_STAGES-1];
        dir_s     = dir_sync[SYNC_STAGES-1];
        // A level flips on the FILT_CYCLES-th consecutive mismatching cycle.
        step_flip = (step_s != step_filt) && (step_run == FW'(FILT_CYCLES - 1));
        dir_flip  = (dir_s != dir_filt) && (dir_run == FW'(FILT_CYCLES - 1));
        accept    = step_filt & ~step_filt_d;
        eff_dir   = dir_filt ^ dir_invert;
        timer_inc = (timer == INT_MAX) ? timer : timer + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_sync      <= '0;
            dir_sync       <= '0;
            step_filt      <= 1'b0;
            dir_filt       <= 1'b0;
            step_filt_d    <= 1'b0;
            step_run       <= '0;
            dir_run        <= '0;
            setup_cnt      <= SW'(DIR_SETUP);
            timer          <= '0;
            seen           <= 1'b0;
            position       <= '0;
            interval       <= '0;
            interval_valid <= 1'b0;
            step_evt       <= 1'b0;
            dir_err        <= 1'b0;
            stall          <= 1'b0;
        end else begin
            step_sync   <= {step_sync[SYNC_STAGES-2:0], step_in};
            dir_sync    <= {dir_sync[SYNC_STAGES-2:0], dir_in};
            step_filt_d <= step_filt;

            if (step_s == step_filt) begin
                step_run <= '0;
            end else if (step_flip) begin
                step_filt <= step_s;
                step_run  <= '0;
            end else begin
                step_run <= step_run + 1'b1;
            end

            if (dir_s == dir_filt) begin
                dir_run <= '0;
            end else if (dir_flip) begin
                dir_filt <= dir_s;
                dir_run  <= '0;
            end else begin
                dir_run <= dir_run + 1'b1;
            end

            if (dir_flip)
                setup_cnt <= '0;
            else if (setup_cnt < SW'(DIR_SETUP))
                setup_cnt <= setup_cnt + 1'b1;

            step_evt       <= 1'b0;
            interval_valid <= 1'b0;

            // clear takes priority over a coincident accepted step.
            if (clear) begin
                position <= '0;
                timer    <= '0;
                seen     <= 1'b0;
                dir_err  <= 1'b0;
                stall    <= 1'b0;
            end else if (accept) begin
                position <= eff_dir ? position + 1'b1 : position - 1'b1;
                step_evt <= 1'b1;
                if (seen) begin
                    interval       <= timer;
                    interval_valid <= 1'b1;
                end
                timer <= INT_WIDTH'(1);
                stall <= (INT_WIDTH'(1) == INT_MAX);
                seen  <= 1'b1;
                if (setup_cnt < SW'(DIR_SETUP))
                    dir_err <= 1'b1;
            end else begin
                timer <= timer_inc;
                stall <= (timer_inc == INT_MAX);
            end
        end
    end
endmodule

// File: tb/tb_kstep_step_decoder.sv
// tb/tb_kstep_step_decoder.sv - scoreboard bench for kstep_step_decoder
module tb_kstep_step_decoder;
    logic        clk = 1'b0;
    logic        rst, step_in, dir_in, dir_invert, clear;
    logic [31:0] position, position8;
    logic [23:0] interval;
    logic [7:0]  interval8;
    logic        interval_valid, step_evt, dir_err, stall;
    logic        interval_valid8, step_evt8, dir_err8, stall8;

    int tests = 0;
    int fails = 0;
    int evt_cnt = 0;
    int iv_cnt = 0;
    logic [31:0] model_pos = '0;
    logic [31:0] exp_pos[$];
    int          exp_iv[$];

    always #5 clk = ~clk;

    kstep_step_decoder dut (
        .clk(clk), .rst(rst), .step_in(step_in), .dir_in(dir_in),
        .dir_invert(dir_invert), .clear(clear), .position(position),
        .interval(interval), .interval_valid(interval_valid),
        .step_evt(step_evt), .dir_err(dir_err), .stall(stall)
    );

    kstep_step_decoder #(.INT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .step_in(step_in), .dir_in(dir_in),
        .dir_invert(dir_invert), .clear(clear), .position(position8),
        .interval(interval8), .interval_valid(interval_valid8),
        .step_evt(step_evt8), .dir_err(dir_err8), .stall(stall8)
    );

    // Output monitor: every pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (step_evt) begin
                evt_cnt++;
                tests++;
                if (exp_pos.size() == 0) begin
                    fails++;
                    $display("FAIL sb_position: unexpected step_evt, position=%h", position);
                end else begin
                    logic [31:0] e;
                    e = exp_pos.pop_front();
                    if (position !== e) begin
                        fails++;
                        $display("FAIL sb_position: got %h expected %h", position, e);
                    end
                end
            end
            if (interval_valid) begin
                iv_cnt++;
                tests++;
                if (exp_iv.size() == 0) begin
                    fails++;
                    $display("FAIL sb_interval: unexpected interval_valid, interval=%0d", interval);
                end else begin
                    int e;
                    e = exp_iv.pop_front();
                    if (interval !== 24'(e)) begin
                        fails++;
                        $display("FAIL sb_interval: got %0d expected %0d", interval, e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_pos = '0;
    endtask

    // 4-cycle high pulse, then low for lo cycles; period = 4 + lo.
    task automatic step_pulse(input int lo, input int exp_interval);
        model_pos = (dir_in ^ dir_invert) ? model_pos + 32'd1 : model_pos - 32'd1;
        exp_pos.push_back(model_pos);
        if (exp_interval >= 0) exp_iv.push_back(exp_interval);
        step_in = 1'b1;
        tick(4);
        step_in = 1'b0;
        tests++;
        if (step_evt !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: step_evt=%b expected 0", step_evt);
        end
        tick(1);
        tests++;
        if (step_evt !== 1'b1 || position !== model_pos) begin
            fails++;
            $display("FAIL latency: step_evt=%b position=%h expected 1/%h", step_evt, position, model_pos);
        end
        tick(lo - 1);
    endtask

    task automatic check_sb_empty(input string name);
        tests++;
        if (exp_pos.size() != 0 || exp_iv.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d positions %0d intervals still expected, expected 0",
                     name, exp_pos.size(), exp_iv.size());
            exp_pos.delete();
            exp_iv.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; step_in = 1'b0; dir_in = 1'b0; dir_invert = 1'b0; clear = 1'b0;
        tick(3);
        tests++;
        if ({position, interval, interval_valid, step_evt, dir_err, stall} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: pos=%h int=%h iv=%b evt=%b err=%b stall=%b expected all 0",
                     position, interval, interval_valid, step_evt, dir_err, stall);
        end
        rst = 1'b0;
        tick(20);
        tests++;
        if ({position, interval, dir_err, stall, position8, interval8, stall8} !== '0 || evt_cnt != 0 || iv_cnt != 0) begin
            fails++;
            $display("FAIL idle_outputs: pos=%h int=%h err=%b stall=%b stall8=%b evts=%0d ivs=%0d expected 0",
                     position, interval, dir_err, stall, stall8, evt_cnt, iv_cnt);
        end
    endtask

    task automatic test_forward();
        int e0, i0;
        do_clear();
        dir_in = 1'b1;
        tick(20);
        e0 = evt_cnt; i0 = iv_cnt;
        for (int i = 0; i < 5; i++) step_pulse(96, (i == 0) ? -1 : 100);
        tests++;
        if (position !== 32'd5 || evt_cnt - e0 != 5 || iv_cnt - i0 != 4) begin
            fails++;
            $display("FAIL forward: pos=%0d evts=%0d ivs=%0d expected 5/5/4", position, evt_cnt - e0, iv_cnt - i0);
        end
        check_sb_empty("forward");
    endtask

    task automatic test_reverse_wrap();
        do_clear();
        dir_in = 1'b0;
        tick(20);
        step_pulse(96, -1);
        tests++;
        if (position !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL wrap_down: got %h expected ffffffff", position);
        end
        dir_invert = 1'b1;
        step_pulse(96, 100);
        step_pulse(96, 100);
        tests++;
        if (position !== 32'd1) begin
            fails++;
            $display("FAIL wrap_up: got %h expected 00000001", position);
        end
        check_sb_empty("reverse");
    endtask

    task automatic test_glitch();
        int e0;
        logic [31:0] p0;
        e0 = evt_cnt; p0 = position;
        for (int i = 0; i < 10; i++) begin
            step_in = 1'b1; tick(1);
            step_in = 1'b0; tick(3);
        end
        tick(10);
        tests++;
        if (position !== p0 || evt_cnt != e0) begin
            fails++;
            $display("FAIL glitch: pos=%h evts=%0d expected %h/0", position, evt_cnt - e0, p0);
        end
    endtask

    task automatic test_dir_setup();
        dir_invert = 1'b0;
        dir_in = 1'b0;
        do_clear();
        tick(20);
        dir_in = 1'b1;
        tick(2);
        step_pulse(96, -1);
        tests++;
        if (dir_err !== 1'b1 || position !== 32'd1) begin
            fails++;
            $display("FAIL setup_violation: err=%b pos=%h expected 1/00000001", dir_err, position);
        end
        tick(30);
        tests++;
        if (dir_err !== 1'b1) begin
            fails++;
            $display("FAIL setup_sticky: err=%b expected 1", dir_err);
        end
        do_clear();
        tests++;
        if (dir_err !== 1'b0) begin
            fails++;
            $display("FAIL setup_clear: err=%b expected 0", dir_err);
        end
        dir_in = 1'b0;
        tick(10);
        step_pulse(96, -1);
        tests++;
        if (dir_err !== 1'b0 || position !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL setup_ok: err=%b pos=%h expected 0/ffffffff", dir_err, position);
        end
        check_sb_empty("dir_setup");
    endtask

    task automatic test_clear_collision();
        int e0, i0;
        e0 = evt_cnt; i0 = iv_cnt;
        step_in = 1'b1;
        tick(4);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        step_in = 1'b0;
        model_pos = '0;
        tick(20);
        tests++;
        if (position !== 32'd0 || evt_cnt != e0 || iv_cnt != i0) begin
            fails++;
            $display("FAIL clear_collision: pos=%h evts=%0d ivs=%0d expected 0/0/0", position, evt_cnt - e0, iv_cnt - i0);
        end
    endtask

    task automatic test_stall();
        do_clear();
        tick(10);
        step_pulse(296, -1);
        tests++;
        if (stall8 !== 1'b1 || stall !== 1'b0) begin
            fails++;
            $display("FAIL stall_level: stall8=%b stall=%b expected 1/0", stall8, stall);
        end
        step_pulse(96, 300);
        tests++;
        if (interval8 !== 8'd255 || stall8 !== 1'b0) begin
            fails++;
            $display("FAIL stall_interval: interval8=%0d stall8=%b expected 255/0", interval8, stall8);
        end
        check_sb_empty("stall");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_glitch();
        test_dir_setup();
        test_clear_collision();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
